// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: load, then rotate N steps.
// Keeps a shadow copy of the register contents for readback.
module shift_seq_ctrl #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] cnt,
  input  logic [3:0] data,
  input  logic       hiz,
  output logic [1:0] S,
  output logic [3:0] D,
  output logic       OE,
  output logic       busy,
  output logic       done,
  output logic [3:0] QM,
  output logic       qm_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] PMAX = 4'(PRESCALE - 1);

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_ROTL = 2'b01;
  localparam logic [1:0] S_ROTR = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  state_t     state, state_n;
  logic [3:0] rem, rem_n;
  logic       dir_r, dir_r_n;
  logic [3:0] data_r, data_r_n;
  logic [3:0] pcnt, pcnt_n;
  logic [1:0] s_n;
  logic [3:0] d_n;
  logic       oe_n;
  logic       busy_n;
  logic       done_n;
  logic [3:0] qm_n;
  logic       qv_n;
  logic [1:0] rot;
  logic [3:0] pcnt_inc;
  logic       step;

  assign rot      = dir_r ? S_ROTR : S_ROTL;
  assign pcnt_inc = pcnt + 4'd1;
  assign step     = (pcnt == PMAX);

  // Outputs are computed for the cycle being entered, then registered,
  // so S/D line up with the state they belong to.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    dir_r_n  = dir_r;
    data_r_n = data_r;
    pcnt_n   = pcnt;
    s_n      = S_HOLD;
    d_n      = D;
    oe_n     = 1'b0;
    done_n   = 1'b0;
    qm_n     = QM;
    qv_n     = qm_valid;
    if (hiz) begin
      state_n = IDLE;
      rem_n   = 4'd0;
      pcnt_n  = 4'd0;
      qv_n    = 1'b0;
      oe_n    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dir_r_n  = dir;
            rem_n    = cnt;
            data_r_n = data;
            d_n      = data;
            s_n      = S_LOAD;
            state_n  = LOAD;
          end
        end
        LOAD: begin
          qm_n   = data_r;
          qv_n   = 1'b1;
          pcnt_n = 4'd0;
          if (rem == 4'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SHIFT;
            s_n     = (PMAX == 4'd0) ? rot : S_HOLD;
          end
        end
        SHIFT: begin
          if (step) begin
            pcnt_n = 4'd0;
            qm_n   = dir_r ? {QM[0], QM[3:1]}
                           : {QM[2:0], QM[3]};
            if (rem != 4'd0) begin
              rem_n = rem - 4'd1;
            end
            if (rem <= 4'd1) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              s_n = (PMAX == 4'd0) ? rot : S_HOLD;
            end
          end else begin
            pcnt_n = pcnt_inc;
            s_n    = (pcnt_inc == PMAX) ? rot : S_HOLD;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rem      <= 4'd0;
      dir_r    <= 1'b0;
      data_r   <= 4'd0;
      pcnt     <= 4'd0;
      S        <= S_HOLD;
      D        <= 4'd0;
      OE       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      QM       <= 4'd0;
      qm_valid <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      dir_r    <= dir_r_n;
      data_r   <= data_r_n;
      pcnt     <= pcnt_n;
      S        <= s_n;
      D        <= d_n;
      OE       <= oe_n;
      busy     <= busy_n;
      done     <= done_n;
      QM       <= qm_n;
      qm_valid <= qv_n;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: PRESCALE=1 and PRESCALE=3 instances on shared
// stimulus, checked cycle by cycle against an arithmetic timeline model.
module tb_shift_seq_ctrl;

  localparam int P0 = 1;
  localparam int P1 = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       dir;
  logic       hiz;
  logic [3:0] cnt;
  logic [3:0] data;

  logic [1:0] s_o[2];
  logic [3:0] d_o[2];
  logic [3:0] qm_o[2];
  logic       oe_o[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       qv_o[2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  shift_seq_ctrl #(.PRESCALE(P0)) u0 (
    .CLK(CLK), .RST(RST), .start(start), .dir(dir),
    .cnt(cnt), .data(data), .hiz(hiz),
    .S(s_o[0]), .D(d_o[0]), .OE(oe_o[0]),
    .busy(busy_o[0]), .done(done_o[0]),
    .QM(qm_o[0]), .qm_valid(qv_o[0])
  );

  shift_seq_ctrl #(.PRESCALE(P1)) u1 (
    .CLK(CLK), .RST(RST), .start(start), .dir(dir),
    .cnt(cnt), .data(data), .hiz(hiz),
    .S(s_o[1]), .D(d_o[1]), .OE(oe_o[1]),
    .busy(busy_o[1]), .done(done_o[1]),
    .QM(qm_o[1]), .qm_valid(qv_o[1])
  );

  // Model: an accepted op is a timeline of cycles k=1..tot after the
  // sampling edge; k=1 is the load cycle, k=tot is the done cycle.
  bit         act[2]  = '{0, 0};
  int         k[2]    = '{0, 0};
  int         mcnt[2] = '{0, 0};
  logic       mdir[2] = '{0, 0};
  logic [3:0] md[2]   = '{0, 0};
  logic [3:0] qm_h[2] = '{0, 0};
  logic [3:0] d_m[2]  = '{0, 0};
  logic       qv_m[2] = '{0, 0};
  logic       oe_m[2] = '{1, 1};

  function automatic int pv(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic logic [3:0] rotn(input logic [3:0] v,
                                      input logic d, input int n);
    logic [3:0] r;
    r = v;
    for (int j = 0; j < n; j++)
      r = d ? {r[0], r[3:1]} : {r[2:0], r[3]};
    return r;
  endfunction

  function automatic int tot(input int i);
    return mcnt[i] * pv(i) + 2;
  endfunction

  function automatic logic [3:0] exp_qm(input int i);
    if (act[i] && k[i] >= 2)
      return rotn(md[i], mdir[i], (k[i] - 2) / pv(i));
    return qm_h[i];
  endfunction

  function automatic int exp_s(input int i);
    if (!act[i]) return 0;
    if (k[i] == 1) return 3;
    if (k[i] == tot(i)) return 0;
    if ((k[i] - 1) % pv(i) == 0) return mdir[i] ? 2 : 1;
    return 0;
  endfunction

  function automatic int exp_done(input int i);
    return (act[i] && k[i] == tot(i)) ? 1 : 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        act[i]  <= 1'b0;
        k[i]    <= 0;
        qm_h[i] <= 4'd0;
        d_m[i]  <= 4'd0;
        qv_m[i] <= 1'b0;
        oe_m[i] <= 1'b1;
      end else if (hiz) begin
        qm_h[i] <= exp_qm(i);
        act[i]  <= 1'b0;
        qv_m[i] <= 1'b0;
        oe_m[i] <= 1'b1;
      end else begin
        oe_m[i] <= 1'b0;
        if (act[i]) begin
          k[i] <= k[i] + 1;
          if (k[i] + 1 == 2) qv_m[i] <= 1'b1;
          if (k[i] + 1 > tot(i)) begin
            act[i]  <= 1'b0;
            qm_h[i] <= rotn(md[i], mdir[i], mcnt[i]);
          end
        end else if (start) begin
          act[i]  <= 1'b1;
          k[i]    <= 1;
          mcnt[i] <= int'(cnt);
          mdir[i] <= dir;
          md[i]   <= data;
          d_m[i]  <= data;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h",
               nm, i, $time, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("S", i, 64'(s_o[i]), 64'(exp_s(i)));
        chk("D", i, 64'(d_o[i]), 64'(d_m[i]));
        chk("OE", i, 64'(oe_o[i]), 64'(oe_m[i]));
        chk("busy", i, 64'(busy_o[i]), 64'(act[i]));
        chk("done", i, 64'(done_o[i]), 64'(exp_done(i)));
        chk("QM", i, 64'(qm_o[i]), 64'(exp_qm(i)));
        chk("qm_valid", i, 64'(qv_o[i]), 64'(qv_m[i]));
      end
    end
  end

  task automatic chk_rst(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_S"}, i, 64'(s_o[i]), 64'd0);
      chk({tag, "_D"}, i, 64'(d_o[i]), 64'd0);
      chk({tag, "_OE"}, i, 64'(oe_o[i]), 64'd1);
      chk({tag, "_busy"}, i, 64'(busy_o[i]), 64'd0);
      chk({tag, "_done"}, i, 64'(done_o[i]), 64'd0);
      chk({tag, "_QM"}, i, 64'(qm_o[i]), 64'd0);
      chk({tag, "_qv"}, i, 64'(qv_o[i]), 64'd0);
    end
  endtask

  // Issue one op and pin its observable shape to hand-computed literals.
  task automatic run_op(input bit nowait, input logic d,
                        input logic [3:0] c, input logic [3:0] v,
                        input logic [3:0] eqm,
                        input int eb0, input int eb1,
                        input logic [63:0] em0, input logic [63:0] em1,
                        input bit inj);
    int         idx = 0;
    int         bc[2];
    int         di[2];
    logic [3:0] qd[2];
    logic [63:0] m[2];
    bit         seen[2];
    bit         fin = 1'b0;
    int         eb[2];
    logic [63:0] em[2];
    eb[0] = eb0; eb[1] = eb1;
    em[0] = em0; em[1] = em1;
    for (int i = 0; i < 2; i++) begin
      bc[i] = 0; di[i] = 0; qd[i] = 4'd0;
      m[i] = 64'd0; seen[i] = 1'b0;
    end
    if (!nowait) begin
      @(posedge CLK);
      #1;
    end
    dir = d; cnt = c; data = v; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    while (!fin && idx < 80) begin
      @(negedge CLK);
      idx++;
      if (inj && idx == 3) begin
        start = 1'b1; data = 4'hF; cnt = 4'h1;
      end
      if (inj && idx == 4) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (idx == 1) begin
          chk("load_S", i, 64'(s_o[i]), 64'd3);
          chk("load_D", i, 64'(d_o[i]), 64'(v));
          chk("load_OE", i, 64'(oe_o[i]), 64'd0);
        end
        if (busy_o[i]) bc[i]++;
        if (idx < 64 && (s_o[i] == 2'b01 || s_o[i] == 2'b10))
          m[i][idx] = 1'b1;
        if (done_o[i] && !seen[i]) begin
          seen[i] = 1'b1;
          di[i] = idx;
          qd[i] = qm_o[i];
        end
      end
      fin = seen[0] && seen[1] && !busy_o[0] && !busy_o[1];
    end
    chk("op_timeout", 0, 64'(fin), 64'd1);
    for (int i = 0; i < 2; i++) begin
      chk("busy_len", i, 64'(bc[i]), 64'(eb[i]));
      chk("done_idx", i, 64'(di[i]), 64'(eb[i]));
      chk("qm_at_done", i, 64'(qd[i]), 64'(eqm));
      chk("step_mask", i, m[i], em[i]);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; dir = 1'b0; hiz = 1'b0;
    cnt = 4'd0; data = 4'd0;
    repeat (3) @(negedge CLK);
    chk_rst("reset");
    chk_en = 1'b1;
    #2 RST = 1'b0;

    // load only; start accepted on the first edge after reset release
    run_op(1'b1, 1'b0, 4'd0, 4'b1001, 4'b1001, 2, 2,
           64'h0, 64'h0, 1'b0);
    run_op(1'b0, 1'b0, 4'd3, 4'b0001, 4'b1000, 5, 11,
           64'h1C, 64'h490, 1'b0);
    // full count, with a start pulse injected while busy
    run_op(1'b0, 1'b0, 4'd15, 4'b0011, 4'b1001, 17, 47,
           64'h1FFFC, 64'h4924_9249_2490, 1'b1);
    run_op(1'b0, 1'b1, 4'd1, 4'b0001, 4'b1000, 3, 5,
           64'h4, 64'h10, 1'b0);

    // abort by hiz while the P=1 instance has rem=2
    @(posedge CLK);
    #1 dir = 1'b0; cnt = 4'd3; data = 4'b0001; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(negedge CLK);
    hiz = 1'b1; start = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("hiz_OE", i, 64'(oe_o[i]), 64'd1);
      chk("hiz_S", i, 64'(s_o[i]), 64'd0);
      chk("hiz_busy", i, 64'(busy_o[i]), 64'd0);
      chk("hiz_qv", i, 64'(qv_o[i]), 64'd0);
      chk("hiz_done", i, 64'(done_o[i]), 64'd0);
    end
    chk("hiz_QM", 0, 64'(qm_o[0]), 64'h2);
    chk("hiz_QM", 1, 64'(qm_o[1]), 64'h1);
    @(negedge CLK);
    for (int i = 0; i < 2; i++)
      chk("hiz_start_ign", i, 64'(busy_o[i]), 64'd0);
    hiz = 1'b0; start = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("hiz_rel_OE", i, 64'(oe_o[i]), 64'd0);
      chk("hiz_rel_done", i, 64'(done_o[i]), 64'd0);
    end

    run_op(1'b0, 1'b0, 4'd2, 4'b0110, 4'b1001, 4, 8,
           64'hC, 64'h90, 1'b0);

    // asynchronous reset between edges, mid-shift
    @(posedge CLK);
    #1 dir = 1'b1; cnt = 4'd3; data = 4'b1000; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1 chk_rst("async_rst");
    #1 RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_OE", i, 64'(oe_o[i]), 64'd0);
      chk("post_rst_busy", i, 64'(busy_o[i]), 64'd0);
      chk("post_rst_done", i, 64'(done_o[i]), 64'd0);
    end
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 2; i++)
      chk("post_rst_nodone", i, 64'(done_o[i]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1, meaning clock cycles per shift step in SHIFT; legal values are 1..15.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a load-then-rotate operation, sampled only in IDLE.
REQ-005 The block SHALL have port dir, input, 1 bit: rotate direction, 0=left, 1=right; captured with start.
REQ-006 The block SHALL have port cnt, input, 4 bits: number of rotate steps, 0..15; captured with start.
REQ-007 The block SHALL have port data, input, 4 bits: load value; captured with start.
REQ-008 The block SHALL have port hiz, input, 1 bit: level request to tri-state the shift register and abort.
REQ-009 The block SHALL have port S, output, 2 bits: registered mode code to the shift register (00 hold, 01 rotate left, 10 rotate right, 11 load).
REQ-010 The block SHALL have port D, output, 4 bits: registered parallel load data to the shift register.
REQ-011 The block SHALL have port OE, output, 1 bit: registered tri-state/clear control to the shift register.
REQ-012 The block SHALL have port busy, output, 1 bit: high in LOAD, SHIFT and DONE.
REQ-013 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-014 The block SHALL have port QM, output, 4 bits: model of the shift register contents.
REQ-015 The block SHALL have port qm_valid, output, 1 bit: QM is trustworthy.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD, SHIFT and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with start=1 and hiz=0, the block SHALL capture dir, cnt and data into rem/dir_r/data_r and go to LOAD.
REQ-018 In LOAD (exactly 1 cycle), the block SHALL drive S=11 and D=data_r; at the end of the cycle QM<=data_r and qm_valid<=1; next state SHALL be DONE if rem=0, else SHIFT.
REQ-019 On entry to SHIFT, the prescale counter SHALL be cleared.
REQ-020 In SHIFT, S SHALL equal 01 (dir_r=0) or 10 (dir_r=1) for exactly one cycle when the prescale counter equals PRESCALE-1, and 00 otherwise; the counter SHALL wrap to 0 after that step cycle.
REQ-021 On each step cycle, rem SHALL decrement by 1 and QM SHALL rotate identically to the register: left QM<={QM[2:0],QM[3]}, right QM<={QM[0],QM[3:1]}.
REQ-022 When the step cycle makes rem=0, next state SHALL be DONE.
REQ-023 DONE SHALL last 1 cycle with done=1 and S=00, then go to IDLE.
REQ-024 In IDLE, S SHALL be 00 and busy=0.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 In any state, hiz=1 SHALL cause OE=1, state<=IDLE, S<=00, rem<=0 and qm_valid<=0 on the next edge; done SHALL NOT pulse and QM SHALL hold.
REQ-027 OE=0 SHALL be driven whenever hiz=0 and RST=0.
REQ-028 start with hiz=1 in the same cycle SHALL be ignored.
REQ-029 For PRESCALE=1, total latency from the start-sampling edge SHALL be 1 (LOAD) + cnt (SHIFT) + 1 (DONE) cycles; busy SHALL be high for cnt+2 cycles.
REQ-030 rem SHALL be a 4-bit down-counter and SHALL never underflow; cnt=15 SHALL produce exactly 15 step pulses.

Reset
REQ-031 RST=1 SHALL immediately, without waiting for CLK, force state=IDLE, S=00, D=0000, OE=1, busy=0, done=0, QM=0000, qm_valid=0, rem=0 and prescale counter=0.
REQ-032 On the first edge after RST falls with hiz=0, OE SHALL go to 0; start SHALL be accepted in that same cycle.
REQ-033 RST asserted mid-operation SHALL abort without a done pulse.

Verification
REQ-034 The bench SHALL cover: data=1001, cnt=0 -> one cycle S=11/D=1001, then done=1 in the next cycle, QM=1001, qm_valid=1, busy high 2 cycles.
REQ-035 The bench SHALL cover: data=0001, dir=0, cnt=3, PRESCALE=1 -> S=01 for 3 consecutive cycles, QM=1000 at done.
REQ-036 The bench SHALL cover: data=0011, dir=0, cnt=15 -> 15 step cycles, QM=1001 at done; and data=0001, dir=1, cnt=1 -> QM=1000.
REQ-037 The bench SHALL cover: PRESCALE=3, cnt=2 -> S=01 on SHIFT cycles 3 and 6 only, done one cycle later, busy high 8 cycles.
REQ-038 The bench SHALL cover: hiz=1 during SHIFT with rem=2 -> next cycle OE=1, S=00, busy=0, qm_valid=0, no done pulse; start during busy is ignored.
REQ-039 The bench SHALL cover: RST pulsed mid-SHIFT between clock edges -> outputs reach reset values before the next edge, with no done pulse.
